// File: rtl/dwt_multilevel_ctrl_if.sv
// RAM and dwt_2 core side bus of the multilevel DWT sequencer.
// The master side is the sequencer; the slave side is the RAM plus streaming core.
interface dwt_multilevel_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
);
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             core_rst;
  logic             core_valid_i;
  logic [WIDTH-1:0] core_din;
  logic             core_valid_o;
  logic [WIDTH-1:0] core_dout;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output core_rst, core_valid_i, core_din,
    input  rd_data, core_valid_o, core_dout
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  core_rst, core_valid_i, core_din,
    output rd_data, core_valid_o, core_dout
  );
endinterface

// File: rtl/dwt_multilevel_ctrl.sv
// Multilevel in-place DWT sequencer: streams RAM[0..len-1] through the dwt_2 core and
// writes results back in place, halving len for each further decomposition level.
module dwt_multilevel_ctrl #(
  parameter int WIDTH      = 16,
  parameter int NUMEL      = 512,
  parameter int AW         = 9,
  parameter int MAX_LEVELS = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           levels,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2:0]           level_o,
  dwt_multilevel_ctrl_if.master bus
);

  localparam int            CW   = AW + 1;
  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LEN0 = CW'(NUMEL);
  localparam logic [2:0]    MAXL = 3'(MAX_LEVELS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       lvl_req;
  logic [2:0]       lvl_clamped;
  logic [CW-1:0]    len;
  logic [CW-1:0]    rd_cnt;
  logic [CW-1:0]    wr_cnt;
  logic [TW-1:0]    timer;
  logic             clr_cnt;
  logic             rd_ret;
  logic             core_valid_q;
  logic [WIDTH-1:0] core_din_q;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             rd_en;
  logic             start_acc;
  logic             next_lvl;
  logic             timeout_hit;
  logic             wr_acc;
  logic             excess;

  always_comb begin
    if (levels == 3'd0)
      lvl_clamped = 3'd1;
    else if (levels > MAXL)
      lvl_clamped = MAXL;
    else
      lvl_clamped = levels;
  end

  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    next_lvl    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        if (clr_cnt)
          state_nxt = S_FEED;
      end
      S_FEED: begin
        if (rd_cnt == len - CW'(1))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Completion wins over a timeout landing on the same cycle.
        if (wr_cnt == len) begin
          if (level_o + 3'd1 < lvl_req) begin
            next_lvl  = 1'b1;
            state_nxt = S_CLR;
          end else begin
            state_nxt = S_FIN;
          end
        end else if (timer == TMAX) begin
          timeout_hit = 1'b1;
          state_nxt   = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);
  assign rd_en    = (state == S_FEED);
  assign wr_acc   = bus.core_valid_o && ((state == S_FEED) || (state == S_DRAIN)) && (wr_cnt < len);
  assign excess   = bus.core_valid_o && !wr_acc;

  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = rd_cnt[AW-1:0];
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.core_rst     = (state == S_IDLE) || (state == S_CLR);
  assign bus.core_valid_i = core_valid_q;
  assign bus.core_din     = core_din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // rd_ret marks the cycle RAM data returns; the core sees it one register later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_req      <= 3'd1;
      level_o      <= 3'd0;
      len          <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      timer        <= '0;
      clr_cnt      <= 1'b0;
      error        <= 1'b0;
      rd_ret       <= 1'b0;
      core_valid_q <= 1'b0;
      core_din_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      rd_ret       <= rd_en;
      core_valid_q <= rd_ret;
      if (rd_ret)
        core_din_q <= bus.rd_data;

      wr_en_q <= wr_acc;
      if (wr_acc) begin
        wr_addr_q <= wr_cnt[AW-1:0];
        wr_data_q <= bus.core_dout;
      end

      if (start_acc) begin
        lvl_req <= lvl_clamped;
        len     <= LEN0;
        level_o <= 3'd0;
      end else if (next_lvl) begin
        level_o <= level_o + 3'd1;
        len     <= len >> 1;
      end

      if (start_acc)
        error <= excess;
      else if (excess || timeout_hit)
        error <= 1'b1;

      if (state == S_CLR) begin
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        timer   <= '0;
        clr_cnt <= ~clr_cnt;
      end else begin
        if (rd_en)
          rd_cnt <= rd_cnt + CW'(1);
        if (wr_acc)
          wr_cnt <= wr_cnt + CW'(1);
        if (state == S_DRAIN)
          timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dwt_multilevel_ctrl.sv
// Directed bench for dwt_multilevel_ctrl: behavioural RAM plus a 3-cycle core model
// whose output is din+1, so each level adds one to every address it covers.
module tb_dwt_multilevel_ctrl;

  localparam int WIDTH      = 16;
  localparam int NUMEL      = 512;
  localparam int AW         = 9;
  localparam int MAX_LEVELS = 4;
  localparam int TIMEOUT    = 1023;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] levels;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] level_o;

  dwt_multilevel_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  dwt_multilevel_ctrl #(
    .WIDTH(WIDTH), .NUMEL(NUMEL), .AW(AW), .MAX_LEVELS(MAX_LEVELS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .levels(levels), .busy(busy),
    .done(done), .error(error), .level_o(level_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] raw [NUMEL];
  logic [WIDTH-1:0] mem [NUMEL];
  logic             load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NUMEL; i++) mem[i] = raw[i];
    end else begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
      if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
    end
  end

  logic             cv1, cv2, cv3;
  logic [WIDTH-1:0] cd1, cd2, cd3;
  int               out_cnt;
  logic             drop_en = 1'b0;
  int               drop_at = 0;
  logic             inject  = 1'b0;

  always @(posedge clk) begin
    if (bus.core_rst) begin
      cv1 <= 1'b0; cv2 <= 1'b0; cv3 <= 1'b0; out_cnt <= 0;
    end else begin
      cv1 <= bus.core_valid_i; cd1 <= bus.core_din + 16'd1;
      cv2 <= cv1; cd2 <= cd1;
      cv3 <= cv2; cd3 <= cd2;
      if (cv3) out_cnt <= out_cnt + 1;
    end
  end

  assign bus.core_valid_o = (cv3 && !(drop_en && out_cnt == drop_at)) || inject;
  assign bus.core_dout    = cd3;

  // Activity monitor, cleared through stats_clr so only this process writes its counters.
  logic stats_clr = 1'b0;
  int   cyc = 0;
  int   rd_total, rd_err, din_err, wr_err, done_cnt, nruns, run_len;
  int   rd_idx, fed_idx, wr_idx, last_rd_cyc, done_cyc;
  int   wr_lvl [8];
  int   runs [8];

  always @(negedge clk) begin
    cyc++;
    if (stats_clr) begin
      rd_total = 0; rd_err = 0; din_err = 0; wr_err = 0; done_cnt = 0;
      nruns = 0; run_len = 0; last_rd_cyc = 0; done_cyc = 0;
      for (int i = 0; i < 8; i++) begin wr_lvl[i] = 0; runs[i] = 0; end
    end else begin
      if (bus.core_rst) begin
        rd_idx = 0; fed_idx = 0; wr_idx = 0; run_len++;
      end else if (run_len != 0) begin
        if (nruns < 8) runs[nruns] = run_len;
        nruns++;
        run_len = 0;
      end
      if (bus.rd_en) begin
        rd_total++;
        if (int'(bus.rd_addr) != rd_idx) rd_err++;
        rd_idx++;
        last_rd_cyc = cyc;
      end
      if (bus.core_valid_i) begin
        if (fed_idx >= NUMEL || bus.core_din !== mem[fed_idx]) din_err++;
        fed_idx++;
      end
      if (bus.wr_en) begin
        wr_lvl[level_o]++;
        if (int'(bus.wr_addr) != wr_idx) wr_err++;
        wr_idx++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    @(negedge clk); #1 stats_clr = 1'b1;
    @(negedge clk); #1 stats_clr = 1'b0;
  endtask

  task automatic load_ram();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] lv);
    @(negedge clk); levels = lv; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_done: done=%b after %0d cycles, required 1", name, done, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [WIDTH-1:0] exp_val(input int a, input int nlev);
    int inc = 0;
    for (int k = 0; k < nlev; k++) if (a < (NUMEL >> k)) inc++;
    return raw[a] + WIDTH'(inc);
  endfunction

  task automatic check_ram(input int nlev, input string name);
    int errs  = 0;
    int first = -1;
    for (int a = 0; a < NUMEL; a++) begin
      if (mem[a] !== exp_val(a, nlev)) begin
        errs++;
        if (first < 0) first = a;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("[TB] FAIL %s_ram: %0d bad words, first addr %0d got %h required %h",
               name, errs, first, mem[first], exp_val(first, nlev));
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic check_stream(input string name);
    check_int({name, "_rd_order"}, rd_err, 0);
    check_int({name, "_din_align"}, din_err, 0);
    check_int({name, "_wr_order"}, wr_err, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; levels = 3'd0;
    repeat (3) @(negedge clk);
    total += 10;
    if ({busy, done, error} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_status: busy/done/error=%b required 000", {busy, done, error});
    end
    if (bus.rd_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_en: got %b required 0", bus.rd_en); end
    if (bus.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b required 0", bus.wr_en); end
    if (bus.core_valid_i !== 1'b0) begin bad++; $display("[TB] FAIL reset_core_valid_i: got %b required 0", bus.core_valid_i); end
    if (bus.core_rst !== 1'b1) begin bad++; $display("[TB] FAIL reset_core_rst: got %b required 1", bus.core_rst); end
    if (level_o !== 3'd0) begin bad++; $display("[TB] FAIL reset_level_o: got %0d required 0", level_o); end
    if (bus.rd_addr !== '0) begin bad++; $display("[TB] FAIL reset_rd_addr: got %0d required 0", bus.rd_addr); end
    if (bus.wr_addr !== '0) begin bad++; $display("[TB] FAIL reset_wr_addr: got %0d required 0", bus.wr_addr); end
    if (bus.wr_data !== '0) begin bad++; $display("[TB] FAIL reset_wr_data: got %h required 0", bus.wr_data); end
    if (bus.core_din !== '0) begin bad++; $display("[TB] FAIL reset_core_din: got %h required 0", bus.core_din); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_one_level();
    load_ram(); clear_stats();
    do_start(3'd1);
    wait_done(5000, "one_level");
    check_int("one_level_reads", rd_total, 512);
    check_int("one_level_writes", wr_lvl[0], 512);
    check_int("one_level_done_pulses", done_cnt, 1);
    check_int("one_level_error", int'(error), 0);
    check_int("one_level_busy_after", int'(busy), 0);
    check_stream("one_level");
    check_ram(1, "one_level");
  endtask

  task automatic test_three_levels();
    load_ram(); clear_stats();
    do_start(3'd3);
    wait_done(5000, "three_levels");
    check_int("three_levels_wr_l0", wr_lvl[0], 512);
    check_int("three_levels_wr_l1", wr_lvl[1], 256);
    check_int("three_levels_wr_l2", wr_lvl[2], 128);
    check_int("three_levels_wr_l3", wr_lvl[3], 0);
    check_int("three_levels_reads", rd_total, 896);
    check_int("three_levels_clr_runs", nruns, 3);
    check_int("three_levels_clr_l1", runs[1], 2);
    check_int("three_levels_clr_l2", runs[2], 2);
    check_int("three_levels_done_pulses", done_cnt, 1);
    check_stream("three_levels");
    check_ram(3, "three_levels");
  endtask

  task automatic test_level_clamp();
    load_ram(); clear_stats();
    do_start(3'd0);
    wait_done(5000, "levels0");
    check_int("levels0_wr_l0", wr_lvl[0], 512);
    check_int("levels0_wr_l1", wr_lvl[1], 0);
    check_ram(1, "levels0");

    load_ram(); clear_stats();
    do_start(3'd7);
    wait_done(5000, "levels7");
    check_int("levels7_wr_l2", wr_lvl[2], 128);
    check_int("levels7_wr_l3", wr_lvl[3], 64);
    check_int("levels7_wr_l4", wr_lvl[4], 0);
    check_int("levels7_done_pulses", done_cnt, 1);
    check_stream("levels7");
    check_ram(MAX_LEVELS, "levels7");
  endtask

  task automatic test_timeout();
    int gap;
    load_ram(); clear_stats();
    drop_en = 1'b1; drop_at = NUMEL - 1;
    do_start(3'd3);
    wait_done(5000, "timeout");
    drop_en = 1'b0;
    gap = done_cyc - last_rd_cyc;
    check_int("timeout_error", int'(error), 1);
    check_int("timeout_done_pulses", done_cnt, 1);
    check_int("timeout_wr_l0", wr_lvl[0], 511);
    check_int("timeout_wr_l1", wr_lvl[1], 0);
    check_int("timeout_gap_in_window", int'(gap >= TIMEOUT && gap <= TIMEOUT + 8), 1);
    check_int("timeout_mem510", int'(mem[510]), int'(raw[510] + 16'd1));
    check_int("timeout_mem511", int'(mem[511]), int'(raw[511]));

    load_ram(); clear_stats();
    do_start(3'd1);
    check_int("timeout_error_cleared", int'(error), 0);
    wait_done(5000, "after_timeout");
    check_int("after_timeout_error", int'(error), 0);
    check_ram(1, "after_timeout");
  endtask

  task automatic test_start_ignored_and_excess();
    load_ram(); clear_stats();
    do_start(3'd1);
    repeat (100) @(negedge clk);
    levels = 3'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(5000, "start_busy");
    repeat (20) @(negedge clk);
    check_int("start_busy_reads", rd_total, 512);
    check_int("start_busy_wr_l1", wr_lvl[1], 0);
    check_int("start_busy_done_pulses", done_cnt, 1);
    check_int("start_busy_idle", int'(busy), 0);
    check_ram(1, "start_busy");

    inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    repeat (3) @(negedge clk);
    check_int("excess_error", int'(error), 1);
    check_int("excess_no_write", wr_lvl[0], 512);
    check_ram(1, "excess");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load_ram(); clear_stats();
    do_start(3'd2);
    while (!(level_o == 3'd1 && bus.rd_en === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_int("reset_mid_reached_l1_feed", int'(level_o == 3'd1 && bus.rd_en === 1'b1), 1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_int("reset_mid_busy", int'(busy), 0);
    check_int("reset_mid_rd_en", int'(bus.rd_en), 0);
    check_int("reset_mid_wr_en", int'(bus.wr_en), 0);
    check_int("reset_mid_core_valid_i", int'(bus.core_valid_i), 0);
    check_int("reset_mid_core_rst", int'(bus.core_rst), 1);
    check_int("reset_mid_level_o", int'(level_o), 0);
    check_int("reset_mid_rd_addr", int'(bus.rd_addr), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load_ram(); clear_stats();
    do_start(3'd2);
    wait_done(5000, "reset_mid_rerun");
    check_int("reset_mid_rerun_error", int'(error), 0);
    check_int("reset_mid_rerun_wr_l1", wr_lvl[1], 256);
    check_stream("reset_mid_rerun");
    check_ram(2, "reset_mid_rerun");
  endtask

  initial begin
    for (int i = 0; i < NUMEL; i++) raw[i] = WIDTH'(i * 7 + 3);
    test_reset();
    test_one_level();
    test_three_levels();
    test_level_clamp();
    test_timeout();
    test_start_ignored_and_excess();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
